// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fir_pkg
//  Purpose  : Shared types, default widths and output rounding helper for the
//             serial FIR engine and its coefficient ROM.
//  Revision : 1.0  initial release
// ============================================================================
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_TAPS   = 16;
  localparam int IDX_WIDTH  = 7;
  localparam int ACC_WIDTH  = 40;
  localparam int OUT_SHIFT  = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_state_t;

  // Round half up, arithmetic shift right, then clamp to a signed 'width'-bit
  // range. Works on a 64-bit sign-extended accumulator (ACC_WIDTH <= 64).
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int width);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coef_rom.sv
`default_nettype none
// ============================================================================
//  Module   : fir_coef_rom
//  Purpose  : Symmetric 16-tap Q1.15 low-pass coefficient ROM with a
//             registered output (tap word valid one cycle after the index).
//  Revision : 1.0  initial release
// ============================================================================
module fir_coef_rom #(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int IDX_WIDTH  = fir_pkg::IDX_WIDTH
) (
  input  logic                  i_clk,
  input  logic [IDX_WIDTH-1:0]  i_idx,
  output logic [DATA_WIDTH-1:0] o_tap
);
  import fir_pkg::*;

  localparam int ROM_W = $clog2(NUM_TAPS);

  localparam logic [DATA_WIDTH-1:0] COEF [NUM_TAPS] = '{
    16'h0565, 16'h0BD9, 16'h0B0B, 16'hFF27, 16'hF3A7, 16'hFB52, 16'h182E, 16'h3384,
    16'h3384, 16'h182E, 16'hFB52, 16'hF3A7, 16'hFF27, 16'h0B0B, 16'h0BD9, 16'h0565
  };

  logic [DATA_WIDTH-1:0] tap_q;

  // Registered lookup; indices past the table read as zero.
  always_ff @(posedge i_clk) begin
    if ({1'b0, i_idx} < (IDX_WIDTH + 1)'(NUM_TAPS)) begin
      tap_q <= COEF[i_idx[ROM_W-1:0]];
    end else begin
      tap_q <= '0;
    end
  end

  assign o_tap = tap_q;

endmodule
`default_nettype wire

// File: rtl/fir_history_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fir_history_ram
//  Purpose  : Circular sample history with one write port, one registered
//             read port addressed by tap offset, and the write pointer.
//  Revision : 1.0  initial release
// ============================================================================
module fir_history_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 16,
  parameter int PTR_W      = $clog2(NUM_TAPS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0]      i_rd_tap,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [PTR_W-1:0]      wr_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [NUM_TAPS];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [PTR_W-1:0]      rd_addr;

  // The pointer has already advanced past the newest sample, so x[n-k] sits
  // at (wr_ptr - 1 - k); power-of-two depth makes the modulo free.
  assign rd_addr = wr_ptr_q - PTR_W'(1) - i_rd_tap;

  // Sample write and pointer advance; reset zeroes the whole history.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (i_wr_en) begin
      mem_q[wr_ptr_q] <= i_wr_data;
      wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
    end
  end

  // Registered read so the sample lines up with the ROM's registered tap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign o_rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/fir_mac_serial.sv
`default_nettype none
// ============================================================================
//  Module   : fir_mac_serial
//  Purpose  : Time-multiplexed single-multiplier FIR. Walks the coefficient
//             ROM one tap per clock, accumulates h[k]*x[n-k], and emits one
//             rounded, saturated output per accepted input sample.
//  Revision : 1.0  initial release
// ============================================================================
module fir_mac_serial #(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int NUM_TAPS   = fir_pkg::NUM_TAPS,
  parameter int IDX_WIDTH  = fir_pkg::IDX_WIDTH,
  parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
  parameter int OUT_SHIFT  = fir_pkg::OUT_SHIFT
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_sample_valid,
  output logic                  o_sample_ready,
  output logic [IDX_WIDTH-1:0]  o_idx,
  input  logic [DATA_WIDTH-1:0] i_tap,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_result_valid
);
  import fir_pkg::*;

  localparam int                   PTR_W    = $clog2(NUM_TAPS);
  localparam int                   PROD_W   = 2 * DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_TAPS - 1);

  fir_state_t                   state_q;
  logic [IDX_WIDTH-1:0]         idx_q;
  logic                         drain_q;
  logic                         ready_q;
  logic                         res_vld_q;
  logic [DATA_WIDTH-1:0]        result_q;
  logic                         tap_vld_q;
  logic                         prod_vld_q;
  logic signed [PROD_W-1:0]     prod_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic [DATA_WIDTH-1:0]        hist_data;
  logic signed [DATA_WIDTH-1:0] rounded;
  logic                         accept;

  assign accept = i_sample_valid && ready_q;

  fir_history_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .PTR_W      (PTR_W)
  ) u_hist (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (accept),
    .i_wr_data  (i_sample),
    .i_rd_tap   (idx_q[PTR_W-1:0]),
    .o_rd_data  (hist_data)
  );

  // Next accumulator value: add the product only when it belongs to a live tap.
  always_comb begin
    acc_d = acc_q;
    if (prod_vld_q) begin
      acc_d = acc_q + ACC_WIDTH'(prod_q);
    end
  end

  // Rounding uses acc_d so the final product is folded in on the DONE edge.
  assign rounded = DATA_WIDTH'(sat_round(64'(acc_d), OUT_SHIFT, DATA_WIDTH));

  // MAC pipeline: tap/sample pair valid one cycle after RUN, product one more.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tap_vld_q  <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
    end else begin
      tap_vld_q  <= (state_q == RUN);
      prod_vld_q <= tap_vld_q;
      prod_q     <= PROD_W'($signed(i_tap)) * PROD_W'($signed(hist_data));
    end
  end

  // Control FSM with registered index, ready, result and valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      ready_q   <= 1'b1;
      res_vld_q <= 1'b0;
      result_q  <= '0;
      acc_q     <= '0;
    end else begin
      acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= RUN;
            idx_q   <= '0;
            acc_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        RUN: begin
          if (idx_q == LAST_IDX) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end else begin
            idx_q <= idx_q + IDX_WIDTH'(1);
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q   <= DONE;
            res_vld_q <= 1'b1;
            result_q  <= rounded;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          res_vld_q <= 1'b0;
          ready_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_sample_ready = ready_q;
  assign o_idx          = idx_q;
  assign o_result       = result_q;
  assign o_result_valid = res_vld_q;

endmodule
`default_nettype wire

// File: doc/fir_mac_serial.md
Name: fir_mac_serial

Overview:
- Time-multiplexed single-multiplier FIR engine. Sits directly downstream of the coefficient ROM.
- Drives the ROM tap index and consumes the registered tap word one cycle later.
- Holds the sample history and computes y[n] = sum over k of h[k]*x[n-k], with one MAC per clock.
- Accepts one input sample per computation and emits one rounded, saturated output sample.

Parameters:
- DATA_WIDTH, 16, sample/coefficient/result width (signed two's complement)
- NUM_TAPS, 16, filter length; power of two, 2..128
- IDX_WIDTH, 7, tap index width; must match the coefficient ROM index port
- ACC_WIDTH, 40, accumulator width; must be at least 2*DATA_WIDTH+log2(NUM_TAPS)
- OUT_SHIFT, 15, right shift applied to the accumulator (Q1.15 coefficients)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  async active-low reset
- i_sample  in  DATA_WIDTH  input sample x[n], signed
- i_sample_valid  in  1  upstream sample valid
- o_sample_ready  out  1  engine can accept a sample
- o_idx  out  IDX_WIDTH  tap index to coefficient ROM
- i_tap  in  DATA_WIDTH  coefficient h[k]; ROM registers it, valid 1 cycle after o_idx
- o_result  out  DATA_WIDTH  filtered sample y[n], signed
- o_result_valid  out  1  one-cycle pulse, y[n] valid

Behaviour:
- Reset (async assert, sync release on i_clk):
  - state=IDLE, o_idx=0, o_result=0, o_result_valid=0, o_sample_ready=1 after release.
  - Accumulator, pipeline registers and write pointer all cleared.
  - All NUM_TAPS history entries cleared to 0.
  - Assertion mid-computation aborts it; no result is emitted.
- Handshake:
  - A sample is accepted on an edge with i_sample_valid && o_sample_ready.
  - o_sample_ready is high only in IDLE. Upstream holds the sample while ready is low.
- History buffer:
  - Circular, NUM_TAPS x DATA_WIDTH. The accepted sample is written at wr_ptr.
  - wr_ptr increments modulo NUM_TAPS on every accept and wraps from NUM_TAPS-1 to 0.
  - For tap k the read address is (wr_ptr_at_accept - k) mod NUM_TAPS, giving x[n-k].
  - Entries not yet written read as 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on accept: acc=0, cnt=0.
  - RUN: o_idx=cnt, cnt++ each cycle. Lasts NUM_TAPS cycles; after cnt reaches NUM_TAPS-1, go to DRAIN.
  - DRAIN: 2 cycles to flush the ROM latency stage and the product register.
  - DONE: o_result, o_result_valid=1 for exactly one cycle, then IDLE.
  - i_sample_valid is ignored outside IDLE.
- Pipeline:
  - Stage 1: o_idx=k. History read address is registered in the same cycle so the sample aligns with i_tap.
  - Stage 2: product = i_tap * x (signed, 2*DATA_WIDTH).
  - Stage 3: acc += sign-extended product.
- Output arithmetic:
  - r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
  - r saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - o_result holds its value until the next DONE.
- Timing:
  - Latency: accept edge to o_result_valid high is NUM_TAPS+3 cycles.
  - Throughput: one sample per NUM_TAPS+4 cycles (includes the IDLE accept cycle).
- No downstream backpressure: a dropped o_result_valid pulse is the consumer's fault.
- o_idx holds its last value (NUM_TAPS-1) outside RUN. The ROM read is harmless.

Decomposition:
- Package fir_pkg:
  - fir_state_t enum (IDLE/RUN/DRAIN/DONE)
  - DATA_WIDTH, NUM_TAPS, IDX_WIDTH, ACC_WIDTH, OUT_SHIFT defaults
  - sat_round helper function
  - Shared with the coefficient ROM so that idx and data widths agree.
- One sub-module, fir_history_ram: circular sample buffer with one write port and one registered read port, plus wr_ptr. The FSM, MAC pipeline and saturation stay in fir_mac_serial.
- The bench instantiates the real coefficient ROM on o_idx/i_tap.

Test Plan (ROM taps 0565,0BD9,0B0B,FF27,F3A7,FB52,182E,3384 mirrored; tap sum 44086):
- Impulse: 0x4000 then 15 zeros -> outputs 0x02B3, 0x05ED, 0x0586, 0xFF94, 0xF9D4, 0xFDA9, 0x0C17, 0x19C2, mirrored; exercises round half up (1381/2 -> 691).
- DC 0x1000 x 20 samples -> outputs ramp up; from the 16th output onward, o_result=0x1587 (5510.75 rounded).
- DC 0x7FFF x 16 -> 16th output saturates to 0x7FFF; DC 0x8000 x 16 -> 16th output 0x8000.
- Handshake: i_sample_valid held high continuously -> o_sample_ready low for 19 cycles per sample, one accept per 20 cycles, o_result_valid exactly 19 cycles after each accept, no sample lost or duplicated.
- Reset mid-RUN (cnt=7): no o_result_valid. After release, impulse 0x4000 gives first output 0x02B3, confirming history cleared and wr_ptr reset.
- Wrap-around: 40 random samples -> every output matches a golden model (wr_ptr passes 15->0 twice).
